// File: rtl/pipe_hazard_scoreboard_if.sv
// Hazard/forwarding bundle between the pipeline datapath and the
// pipe_hazard_scoreboard controller.
//   D-stage inputs : ra_d, use_d, wa_d, regwrite_d, memtoreg_d, multicycle_d, pcs_d
//   E-stage input  : branch_taken_e
//   outputs        : stall_f, stall_d, flush_d, stall_e, flush_e, flush_m, fwd_e, busy_e
// master = datapath side (drives decode info), slave = controller side.
interface pipe_hazard_scoreboard_if #(
    parameter int AW   = 4,
    parameter int NSRC = 2
);
    logic [NSRC*AW-1:0] ra_d;
    logic [NSRC-1:0]    use_d;
    logic [AW-1:0]      wa_d;
    logic               regwrite_d;
    logic               memtoreg_d;
    logic               multicycle_d;
    logic               pcs_d;
    logic               branch_taken_e;
    logic               stall_f;
    logic               stall_d;
    logic               flush_d;
    logic               stall_e;
    logic               flush_e;
    logic               flush_m;
    logic [NSRC*2-1:0]  fwd_e;
    logic               busy_e;

    modport master (
        output ra_d, use_d, wa_d, regwrite_d, memtoreg_d, multicycle_d, pcs_d, branch_taken_e,
        input  stall_f, stall_d, flush_d, stall_e, flush_e, flush_m, fwd_e, busy_e
    );

    modport slave (
        input  ra_d, use_d, wa_d, regwrite_d, memtoreg_d, multicycle_d, pcs_d, branch_taken_e,
        output stall_f, stall_d, flush_d, stall_e, flush_e, flush_m, fwd_e, busy_e
    );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard and forwarding controller for the 5-stage F/D/E/M/W core.
// Keeps a shadow pipeline of destination tags for E/M/W so the datapath
// does not compute register matches itself.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high, clears all tracking state
//   hz    - slave side of pipe_hazard_scoreboard_if (decode info in,
//           stall/flush enables and per-source forward selects out)
// fwd_e encoding per source (2 bits): 00 register file, 01 ResultW, 10 ALUOutM.
module pipe_hazard_scoreboard #(
    parameter int AW      = 4,
    parameter int NSRC    = 2,
    parameter int MUL_LAT = 3,
    parameter int PC_REG  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    pipe_hazard_scoreboard_if.slave   hz
);
    localparam int             CW       = $clog2(MUL_LAT + 1);
    localparam logic [AW-1:0]  PC_ADDR  = AW'(PC_REG);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(MUL_LAT - 1);

    // A stage holding a valid register write to address a; the PC register is never tracked.
    function automatic logic hit_fn(input logic v, input logic rw,
                                    input logic [AW-1:0] wa, input logic [AW-1:0] a);
        return v & rw & (wa == a) & (a != PC_ADDR);
    endfunction

    // E shadow stage (sources kept for forwarding select)
    logic               e_valid_r, e_regwrite_r, e_memtoreg_r, e_pcs_r, e_mc_r;
    logic [AW-1:0]      e_wa_r;
    logic [NSRC*AW-1:0] e_ra_r;
    logic [NSRC-1:0]    e_use_r;
    // M and W shadow stages; a load's memtoreg only matters while it sits in E
    logic               m_valid_r, m_regwrite_r, m_pcs_r;
    logic [AW-1:0]      m_wa_r;
    logic               w_valid_r, w_regwrite_r, w_pcs_r;
    logic [AW-1:0]      w_wa_r;
    logic [CW-1:0]      cnt_r;

    logic              busy_s, ldstall_s, pcwp_s, bt_s;
    logic              stall_d_s, stall_e_s, flush_e_s, flush_m_s;
    logic [NSRC*2-1:0] fwd_s;

    // Hazard detection, forwarding selects and stall/flush enables.
    always_comb begin
        busy_s    = e_valid_r & e_mc_r & (cnt_r != {CW{1'b0}});
        ldstall_s = 1'b0;
        fwd_s     = {(NSRC*2){1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            ldstall_s = ldstall_s | (hz.use_d[i] & e_memtoreg_r &
                        hit_fn(e_valid_r, e_regwrite_r, e_wa_r, hz.ra_d[i*AW +: AW]));
            if (e_use_r[i] && hit_fn(m_valid_r, m_regwrite_r, m_wa_r, e_ra_r[i*AW +: AW])) begin
                fwd_s[i*2 +: 2] = 2'b10;
            end else if (e_use_r[i] && hit_fn(w_valid_r, w_regwrite_r, w_wa_r, e_ra_r[i*AW +: AW])) begin
                fwd_s[i*2 +: 2] = 2'b01;
            end else begin
                fwd_s[i*2 +: 2] = 2'b00;
            end
        end
        pcwp_s    = hz.pcs_d | (e_valid_r & e_pcs_r) | (m_valid_r & m_pcs_r);
        // A taken branch cannot redirect while a multi-cycle op owns E.
        bt_s      = hz.branch_taken_e & ~busy_s;
        stall_d_s = ldstall_s | busy_s;
        stall_e_s = busy_s;
        flush_e_s = (ldstall_s & ~busy_s) | bt_s;
        flush_m_s = busy_s;
    end

    assign hz.stall_f = ldstall_s | pcwp_s | busy_s;
    assign hz.stall_d = stall_d_s;
    assign hz.flush_d = bt_s | ((pcwp_s | (w_valid_r & w_pcs_r)) & ~stall_d_s);
    assign hz.stall_e = stall_e_s;
    assign hz.flush_e = flush_e_s;
    assign hz.flush_m = flush_m_s;
    assign hz.fwd_e   = fwd_s;
    assign hz.busy_e  = busy_s;

    // Shadow pipeline advance and multi-cycle occupancy counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid_r    <= 1'b0;
            e_regwrite_r <= 1'b0;
            e_memtoreg_r <= 1'b0;
            e_pcs_r      <= 1'b0;
            e_mc_r       <= 1'b0;
            e_wa_r       <= {AW{1'b0}};
            e_ra_r       <= {(NSRC*AW){1'b0}};
            e_use_r      <= {NSRC{1'b0}};
            m_valid_r    <= 1'b0;
            m_regwrite_r <= 1'b0;
            m_pcs_r      <= 1'b0;
            m_wa_r       <= {AW{1'b0}};
            w_valid_r    <= 1'b0;
            w_regwrite_r <= 1'b0;
            w_pcs_r      <= 1'b0;
            w_wa_r       <= {AW{1'b0}};
            cnt_r        <= {CW{1'b0}};
        end else begin
            w_valid_r    <= m_valid_r;
            w_regwrite_r <= m_regwrite_r;
            w_pcs_r      <= m_pcs_r;
            w_wa_r       <= m_wa_r;
            // While E is busy its op is held, so M receives a bubble.
            m_valid_r    <= flush_m_s ? 1'b0 : e_valid_r;
            m_regwrite_r <= e_regwrite_r;
            m_pcs_r      <= e_pcs_r;
            m_wa_r       <= e_wa_r;
            if (stall_e_s) begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end else if (flush_e_s) begin
                e_valid_r <= 1'b0;
            end else begin
                e_valid_r    <= 1'b1;
                e_regwrite_r <= hz.regwrite_d;
                e_memtoreg_r <= hz.memtoreg_d;
                e_pcs_r      <= hz.pcs_d;
                e_mc_r       <= hz.multicycle_d;
                e_wa_r       <= hz.wa_d;
                e_ra_r       <= hz.ra_d;
                e_use_r      <= hz.use_d;
                // Loaded with MUL_LAT-1 so the op stays in E for MUL_LAT cycles.
                cnt_r        <= hz.multicycle_d ? CNT_LOAD : {CW{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Randomized self-checking bench for pipe_hazard_scoreboard against a
// behavioural model that tracks instructions per stage and counts the age
// of the op in E.
module tb_pipe_hazard_scoreboard;
    localparam int AW = 4, NSRC = 2, MUL_LAT = 3, PC_REG = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.AW(AW), .NSRC(NSRC)) hz ();

    pipe_hazard_scoreboard #(.AW(AW), .NSRC(NSRC), .MUL_LAT(MUL_LAT), .PC_REG(PC_REG)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        bit                       v;
        bit [AW-1:0]              wa;
        bit                       rw;
        bit                       mtr;
        bit                       pcs;
        bit                       mc;
        bit [NSRC-1:0][AW-1:0]    ra;
        bit [NSRC-1:0]            used;
    } ent_t;

    ent_t pipe_m [3];   // 0 = E, 1 = M, 2 = W
    int   e_age;        // cycles the current E op has spent in E
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int s, input bit [AW-1:0] a);
        return pipe_m[s].v && pipe_m[s].rw && (pipe_m[s].wa == a) && (int'(a) != PC_REG);
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 3; s++) pipe_m[s] = '{default: '0};
        e_age = 0;
    endtask

    // One cycle: drive D inputs, compare every output against the model, advance the model.
    task automatic step(input bit rst, input bit [NSRC-1:0][AW-1:0] ra, input bit [NSRC-1:0] us,
                        input bit [AW-1:0] wa, input bit rw, input bit mtr, input bit mc,
                        input bit pcs, input bit bte);
        bit busy, ld, pcwp, bt, sf, sd, fd, fe;
        bit [NSRC*2-1:0] fwd;
        ent_t d;
        @(negedge clk);
        reset = rst;
        for (int i = 0; i < NSRC; i++) hz.ra_d[i*AW +: AW] = ra[i];
        hz.use_d = us; hz.wa_d = wa; hz.regwrite_d = rw; hz.memtoreg_d = mtr;
        hz.multicycle_d = mc; hz.pcs_d = pcs; hz.branch_taken_e = bte;
        #1;
        busy = pipe_m[0].v && pipe_m[0].mc && (e_age < MUL_LAT);
        ld = 1'b0;
        fwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (us[i] && pipe_m[0].mtr && m_hit(0, ra[i])) ld = 1'b1;
            if (pipe_m[0].used[i]) begin
                if (m_hit(1, pipe_m[0].ra[i]))      fwd[2*i +: 2] = 2'b10;
                else if (m_hit(2, pipe_m[0].ra[i])) fwd[2*i +: 2] = 2'b01;
            end
        end
        pcwp = pcs || (pipe_m[0].v && pipe_m[0].pcs) || (pipe_m[1].v && pipe_m[1].pcs);
        bt = bte && !busy;
        sd = ld || busy;
        sf = ld || pcwp || busy;
        fd = bt || ((pcwp || (pipe_m[2].v && pipe_m[2].pcs)) && !sd);
        fe = (ld && !busy) || bt;
        check_val("stall_f", 32'(hz.stall_f), 32'(sf));
        check_val("stall_d", 32'(hz.stall_d), 32'(sd));
        check_val("flush_d", 32'(hz.flush_d), 32'(fd));
        check_val("stall_e", 32'(hz.stall_e), 32'(busy));
        check_val("flush_e", 32'(hz.flush_e), 32'(fe));
        check_val("flush_m", 32'(hz.flush_m), 32'(busy));
        check_val("busy_e",  32'(hz.busy_e),  32'(busy));
        check_val("fwd_e",   32'(hz.fwd_e),   32'(fwd));
        if (rst) begin
            clear_model();
        end else begin
            pipe_m[2] = pipe_m[1];
            pipe_m[1] = pipe_m[0];
            if (busy) pipe_m[1].v = 1'b0;
            if (busy) begin
                e_age++;
            end else if (fe) begin
                pipe_m[0].v = 1'b0;
            end else begin
                d.v = 1'b1; d.wa = wa; d.rw = rw; d.mtr = mtr; d.pcs = pcs; d.mc = mc;
                d.ra = ra; d.used = us;
                pipe_m[0] = d;
                e_age = 1;
            end
        end
    endtask

    task automatic idle(input bit rst);
        step(rst, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_stalls"}, {26'd0, hz.stall_f, hz.stall_d, hz.flush_d,
                  hz.stall_e, hz.flush_e, hz.flush_m}, 32'd0);
        check_val({tag, "_busy"}, 32'(hz.busy_e), 32'd0);
        check_val({tag, "_fwd"}, 32'(hz.fwd_e), 32'd0);
    endtask

    function automatic bit [AW-1:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? AW'(PC_REG) : AW'($urandom_range(1, 3));
    endfunction

    initial begin
        bit [NSRC-1:0][AW-1:0] ra;
        reset = 1'b1;
        hz.ra_d = '0; hz.use_d = '0; hz.wa_d = '0; hz.regwrite_d = 1'b0; hz.memtoreg_d = 1'b0;
        hz.multicycle_d = 1'b0; hz.pcs_d = 1'b0; hz.branch_taken_e = 1'b0;
        repeat (2) @(posedge clk);
        clear_model();
        idle(1'b0);
        check_all_zero("reset");

        // ADD r1 then SUB r1 as source 0, then a second consumer of r1
        ra[0] = 4'd2; ra[1] = 4'd3;
        step(1'b0, ra, 2'b11, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ra[0] = 4'd1;
        step(1'b0, ra, 2'b01, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, ra, 2'b01, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("fwd_m_prio", 32'(hz.fwd_e[1:0]), 32'd2);
        idle(1'b0);
        check_val("fwd_w", 32'(hz.fwd_e[1:0]), 32'd1);
        repeat (3) idle(1'b0);

        // LDR r2 then consumer of r2: one load-use bubble
        step(1'b0, ra, 2'b00, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        ra[0] = 4'd2;
        step(1'b0, ra, 2'b01, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("ldstall_f", 32'(hz.stall_f), 32'd1);
        check_val("ldstall_fe", 32'(hz.flush_e), 32'd1);
        repeat (3) idle(1'b0);

        // Multi-cycle op, reset asserted on its first E cycle
        step(1'b0, ra, 2'b00, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check_val("mc_busy", 32'(hz.busy_e), 32'd1);
        idle(1'b0);
        check_all_zero("mc_abort");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit [NSRC-1:0] us;
            for (int i = 0; i < NSRC; i++) ra[i] = rnd_addr();
            us = NSRC'($urandom);
            step(($urandom_range(0, 99) < 2), ra, us, rnd_addr(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
